// File: rtl/zpu_fw_loader.sv
// Firmware stream to ZPU boot-loader bridge: turns one AXI-Stream packet (start address,
// then data words) into acked settings-bus writes with timeout and status reporting.
module zpu_fw_loader #(
    parameter int                    ADDR_WIDTH  = 16,
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] MAX_ADDR    = 16'h7FFC,
    parameter logic [3:0]            SR_ADDR_REG = 4'h0,
    parameter logic [3:0]            SR_DATA_REG = 4'h1,
    parameter int                    ACK_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] i_tdata,
    input  logic                  i_tlast,
    input  logic                  i_tvalid,
    output logic                  i_tready,
    output logic                  ldr_stb,
    output logic                  ldr_wea,
    output logic [ADDR_WIDTH-1:0] ldr_addra,
    output logic [DATA_WIDTH-1:0] ldr_dina,
    input  logic                  ldr_acka,
    output logic                  busy,
    output logic                  done,
    output logic                  swapped,
    output logic                  err,
    output logic [1:0]            err_code,
    output logic [13:0]           word_count,
    output logic [DATA_WIDTH-1:0] checksum
);
    localparam int                    TW       = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0]         TMO_INIT = TW'(ACK_TIMEOUT - 1);
    localparam logic [DATA_WIDTH-1:0] MAX_EXT  = DATA_WIDTH'(MAX_ADDR);

    typedef enum logic [2:0] {IDLE, ADDR_WR, DATA_WAIT, DATA_WR, GAP, DRAIN} state_t;

    state_t                  state_q, state_d;
    // One spare MSB so the word after MAX_ADDR reads as an overflow instead of wrapping to 0.
    logic [ADDR_WIDTH-3:0]   cur_addr_q, cur_addr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    last_q, last_d;
    logic [TW-1:0]           tmo_q, tmo_d;
    logic                    tready_q, tready_d;
    logic                    done_q, done_d;
    logic                    swapped_q, swapped_d;
    logic                    err_q, err_d;
    logic [1:0]              err_code_q, err_code_d;
    logic [13:0]             word_count_q, word_count_d;
    logic [DATA_WIDTH-1:0]   checksum_q, checksum_d;

    logic                    fire;
    logic [ADDR_WIDTH-1:0]   cur_byte;

    assign fire     = i_tvalid && tready_q;
    assign cur_byte = {cur_addr_q, 2'b00};

    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        data_d       = data_q;
        last_d       = last_q;
        tmo_d        = tmo_q;
        done_d       = 1'b0;
        swapped_d    = 1'b0;
        err_d        = 1'b0;
        err_code_d   = err_code_q;
        word_count_d = word_count_q;
        checksum_d   = checksum_q;

        unique case (state_q)
            IDLE: begin
                if (fire) begin
                    word_count_d = '0;
                    checksum_d   = '0;
                    err_code_d   = 2'd0;
                    data_d       = i_tdata;
                    last_d       = 1'b0;
                    if ((i_tdata[1:0] != 2'b00) || (i_tdata > MAX_EXT) || i_tlast) begin
                        err_d      = 1'b1;
                        err_code_d = 2'd1;
                        state_d    = i_tlast ? IDLE : DRAIN;
                    end else begin
                        cur_addr_d = {1'b0, i_tdata[ADDR_WIDTH-2:2]};
                        tmo_d      = TMO_INIT;
                        state_d    = ADDR_WR;
                    end
                end
            end
            ADDR_WR, DATA_WR: begin
                if (ldr_acka) begin
                    state_d = GAP;
                    if (state_q == DATA_WR) begin
                        word_count_d = word_count_q + 14'd1;
                        checksum_d   = checksum_q + data_q;
                        cur_addr_d   = cur_addr_q + 1'b1;
                        swapped_d    = (cur_byte == MAX_ADDR);
                        done_d       = last_q;
                    end
                end else if (tmo_q == '0) begin
                    err_d      = 1'b1;
                    err_code_d = 2'd3;
                    state_d    = (state_q == DATA_WR && last_q) ? IDLE : DRAIN;
                end else begin
                    tmo_d = tmo_q - TW'(1);
                end
            end
            GAP: state_d = last_q ? IDLE : DATA_WAIT;
            DATA_WAIT: begin
                if (fire) begin
                    data_d = i_tdata;
                    last_d = i_tlast;
                    if (cur_byte > MAX_ADDR) begin
                        err_d      = 1'b1;
                        err_code_d = 2'd2;
                        state_d    = i_tlast ? IDLE : DRAIN;
                    end else begin
                        tmo_d   = TMO_INIT;
                        state_d = DATA_WR;
                    end
                end
            end
            DRAIN: if (fire && i_tlast) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Ready is registered from the next state so it reads 0 while in reset.
        tready_d = (state_d == IDLE) || (state_d == DATA_WAIT) || (state_d == DRAIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cur_addr_q   <= '0;
            data_q       <= '0;
            last_q       <= 1'b0;
            tmo_q        <= '0;
            tready_q     <= 1'b0;
            done_q       <= 1'b0;
            swapped_q    <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= 2'd0;
            word_count_q <= '0;
            checksum_q   <= '0;
        end else begin
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            data_q       <= data_d;
            last_q       <= last_d;
            tmo_q        <= tmo_d;
            tready_q     <= tready_d;
            done_q       <= done_d;
            swapped_q    <= swapped_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
            word_count_q <= word_count_d;
            checksum_q   <= checksum_d;
        end
    end

    assign i_tready   = tready_q;
    assign ldr_stb    = (state_q == ADDR_WR) || (state_q == DATA_WR);
    assign ldr_wea    = ldr_stb;
    assign ldr_addra  = (state_q == ADDR_WR) ? ADDR_WIDTH'({SR_ADDR_REG, 2'b00}) :
                        (state_q == DATA_WR) ? ADDR_WIDTH'({SR_DATA_REG, 2'b00}) : '0;
    assign ldr_dina   = data_q;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign swapped    = swapped_q;
    assign err        = err_q;
    assign err_code   = err_code_q;
    assign word_count = word_count_q;
    assign checksum   = checksum_q;

endmodule

// File: tb/tb_zpu_fw_loader.sv
// Bench for zpu_fw_loader: randomized packets and ack latencies checked against a
// packet-level model of the expected loader writes and status.
module tb_zpu_fw_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] i_tdata = '0;
    logic        i_tlast = 1'b0;
    logic        i_tvalid = 1'b0;
    logic        i_tready;
    logic        ldr_stb, ldr_wea;
    logic [15:0] ldr_addra;
    logic [31:0] ldr_dina;
    logic        ldr_acka = 1'b0;
    logic        busy, done, swapped, err;
    logic [1:0]  err_code;
    logic [13:0] word_count;
    logic [31:0] checksum;

    always #5 clk = ~clk;

    zpu_fw_loader dut (
        .clk(clk), .rst_n(rst_n),
        .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
        .ldr_stb(ldr_stb), .ldr_wea(ldr_wea), .ldr_addra(ldr_addra), .ldr_dina(ldr_dina),
        .ldr_acka(ldr_acka), .busy(busy), .done(done), .swapped(swapped), .err(err),
        .err_code(err_code), .word_count(word_count), .checksum(checksum)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ack responder controls
    int lat_max = 0, lat_fixed = 1, noack_idx = -1, wr_idx = 0, gap_max = 0;
    int r_age = 0, r_lat = 0;
    bit r_prev = 0, r_noack = 0;
    bit abort = 0;

    // monitor state
    bit          m_pstb = 0, m_pack = 0;
    logic [15:0] m_pa = '0;
    logic [31:0] m_pd = '0;
    int          m_age = 0;
    logic [47:0] got_w[$];
    int          n_done = 0, n_err = 0, n_swap = 0, n_sd = 0;
    logic [1:0]  m_code = '0;

    // model
    logic [31:0] pkt[$];
    logic [47:0] exp_w[$];
    int          e_done, e_err, e_swap, e_sd, e_wc;
    logic [1:0]  e_code;
    logic [31:0] e_cs;

    initial begin
        forever begin
            @(negedge clk);
            if (ldr_stb) begin
                if (!r_prev) begin
                    r_noack = (wr_idx == noack_idx);
                    wr_idx++;
                    r_age = 0;
                    r_lat = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, lat_max));
                end
                ldr_acka = !r_noack && (r_age == r_lat);
                r_age++;
            end else begin
                ldr_acka = 1'b0;
            end
            r_prev = ldr_stb;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                m_pstb = 0; m_pack = 0; m_age = 0;
            end else begin
                chk("wea_eq_stb", ldr_wea, ldr_stb);
                if (ldr_stb) chk("tready_low_in_write", i_tready, 0);
                if (m_pstb && m_pack) chk("stb_after_ack", ldr_stb, 0);
                if (m_pstb && !m_pack && ldr_stb) begin
                    chk("addra_stable", ldr_addra, m_pa);
                    chk("dina_stable", ldr_dina, m_pd);
                end
                if (m_pstb && !m_pack && !ldr_stb) chk("ack_timeout_len", m_age, 16);
                if (ldr_stb && ldr_acka) got_w.push_back({ldr_addra, ldr_dina});
                if (done) n_done++;
                if (swapped) n_swap++;
                if (done && swapped) n_sd++;
                if (err) begin n_err++; m_code = err_code; end
                m_age  = ldr_stb ? m_age + 1 : 0;
                m_pstb = ldr_stb; m_pack = ldr_acka; m_pa = ldr_addra; m_pd = ldr_dina;
            end
        end
    end

    // Packet-level expectation: which writes get acked and how the packet ends.
    // noack: index of the write whose ack is withheld (0 = address write, -1 = none).
    function automatic void model(input logic [31:0] h, input int noack);
        int n;
        n = pkt.size();
        exp_w.delete();
        e_done = 0; e_err = 0; e_swap = 0; e_sd = 0; e_wc = 0; e_code = 0; e_cs = 0;
        if (h[1:0] != 2'b00 || h > 32'h7FFC || n == 0) begin
            e_err = 1; e_code = 1; return;
        end
        if (noack == 0) begin
            e_err = 1; e_code = 3; return;
        end
        exp_w.push_back({16'h0000, h});
        for (int i = 0; i < n; i++) begin
            longint a;
            a = longint'(h) + 4 * i;
            if (a > 'h7FFC) begin e_err = 1; e_code = 2; return; end
            if (noack == i + 1) begin e_err = 1; e_code = 3; return; end
            exp_w.push_back({16'h0004, pkt[i]});
            e_wc++;
            e_cs += pkt[i];
            if (a == 'h7FFC) e_swap++;
        end
        e_done = 1;
        e_sd   = (longint'(h) + 4 * (n - 1) == 'h7FFC) ? 1 : 0;
    endfunction

    task automatic send_beat(input logic [31:0] d, input logic l);
        int w;
        if (abort) return;
        repeat ($urandom_range(0, gap_max)) @(negedge clk);
        i_tdata = d; i_tlast = l; i_tvalid = 1'b1;
        w = 0;
        while (!i_tready && !abort && w < 300) begin @(negedge clk); w++; end
        if (w >= 300) chk("tready_wait", i_tready, 1);
        @(negedge clk);
        i_tvalid = 1'b0; i_tlast = 1'b0;
    endtask

    task automatic send_pkt(input logic [31:0] h);
        send_beat(h, pkt.size() == 0);
        for (int i = 0; i < pkt.size(); i++) begin
            if (abort) break;
            send_beat(pkt[i], i == pkt.size() - 1);
        end
    endtask

    task automatic run_pkt(input logic [31:0] h, input int noack, input string tag);
        int w;
        model(h, noack);
        got_w.delete();
        n_done = 0; n_err = 0; n_swap = 0; n_sd = 0; m_code = 0;
        wr_idx = 0; noack_idx = noack;
        send_pkt(h);
        w = 0;
        while (busy && w < 400) begin @(negedge clk); w++; end
        chk({tag, "_idle"}, busy, 0);
        repeat (3) @(negedge clk);
        chk({tag, "_nwr"}, got_w.size(), exp_w.size());
        for (int i = 0; i < exp_w.size() && i < got_w.size(); i++)
            chk({tag, "_wr"}, got_w[i], exp_w[i]);
        chk({tag, "_done"}, n_done, e_done);
        chk({tag, "_err"}, n_err, e_err);
        chk({tag, "_code"}, err_code, e_code);
        if (e_err != 0) chk({tag, "_code_at_pulse"}, m_code, e_code);
        chk({tag, "_swap"}, n_swap, e_swap);
        chk({tag, "_swap_done"}, n_sd, e_sd);
        chk({tag, "_wc"}, word_count, e_wc);
        chk({tag, "_cs"}, checksum, e_cs);
        chk({tag, "_tready"}, i_tready, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ctl", {i_tready, ldr_stb, ldr_wea, busy, done, swapped, err, err_code,
                        word_count, ldr_addra}, 0);
        chk("rst_data", {ldr_dina, checksum}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        lat_fixed = 1; gap_max = 0;
        pkt = '{32'h11111111, 32'h22222222, 32'hF0000000};
        run_pkt(32'h7FF4, -1, "t1");
        chk("t1_nwr_lit", got_w.size(), 4);
        chk("t1_wr0_lit", got_w[0], {16'h0000, 32'h00007FF4});
        chk("t1_wr3_lit", got_w[3], {16'h0004, 32'hF0000000});
        chk("t1_cs_lit", checksum, 32'h23333333);
        chk("t1_wc_lit", word_count, 3);
        chk("t1_sd_lit", n_sd, 1);

        pkt = '{32'hAAAA0001, 32'hBBBB0002};
        run_pkt(32'h0000_0002, -1, "t2");
        chk("t2_code_lit", err_code, 1);
        chk("t2_nwr_lit", got_w.size(), 0);

        pkt = '{32'd1, 32'd2, 32'd3};
        run_pkt(32'h0010, -1, "t2b");
        chk("t2b_cs_lit", checksum, 6);

        pkt = '{32'h12345678, 32'h9ABCDEF0};
        run_pkt(32'h7FFC, -1, "t3");
        chk("t3_code_lit", err_code, 2);
        chk("t3_wc_lit", word_count, 1);
        chk("t3_done_lit", n_done, 0);
        chk("t3_swap_lit", n_swap, 1);

        pkt = '{32'hA, 32'hB, 32'hC, 32'hD};
        run_pkt(32'h0040, 1, "t4");
        chk("t4_code_lit", err_code, 3);
        chk("t4_wc_lit", word_count, 0);
        chk("t4_nwr_lit", got_w.size(), 1);

        lat_fixed = -1; lat_max = 5; gap_max = 3;
        pkt.delete();
        for (int i = 0; i < 64; i++) pkt.push_back($urandom);
        run_pkt(32'h0100, -1, "t5");
        chk("t5_wc_lit", word_count, 64);

        for (int k = 0; k < 24; k++) begin
            int r, n, na;
            logic [31:0] h;
            r = $urandom_range(0, 9);
            if (r == 0)     h = $urandom;
            else if (r < 3) h = 32'h7FE8 + 32'($urandom_range(0, 5)) * 4;
            else            h = 32'($urandom_range(0, 8191)) << 2;
            n = $urandom_range(0, 6);
            pkt.delete();
            for (int i = 0; i < n; i++) pkt.push_back($urandom);
            na = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, n)) : -1;
            run_pkt(h, na, "rnd");
        end

        lat_fixed = 5; gap_max = 0; wr_idx = 0; noack_idx = -1;
        pkt = '{32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404};
        fork
            send_pkt(32'h0200);
            begin : rst_proc
                int w;
                w = 0;
                while (!(ldr_stb && ldr_addra == 16'h0004) && w < 500) begin
                    @(negedge clk); w++;
                end
                chk("rst_mid_reach", ldr_addra, 16'h0004);
                #1;
                rst_n = 1'b0; abort = 1'b1; i_tvalid = 1'b0;
                #1;
                chk("rst_mid_ctl", {i_tready, ldr_stb, ldr_wea, busy, done, swapped, err,
                                    err_code, word_count, ldr_addra}, 0);
                chk("rst_mid_data", {ldr_dina, checksum}, 0);
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
            end
        join
        abort = 1'b0;
        repeat (2) @(negedge clk);
        lat_fixed = 2;
        run_pkt(32'h0200, -1, "post_rst");
        chk("post_rst_wc_lit", word_count, 4);
        chk("post_rst_cs_lit", checksum, 32'h0A0A0A0A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/zpu_fw_loader.md
Name: zpu_fw_loader

Overview:
- Upstream feeder for the ZPU boot RAM loader port.
- Accepts a firmware packet on a 32-bit AXI-Stream input and converts it into settings-bus style Wishbone writes.
- Packet format: word 0 is the start byte address; each following word is one data word.
- Writes go to the loader's address register (once) and then its data register (once per word), with per-write ack handshake, timeout, and error/status reporting.

Parameters:
- ADDR_WIDTH, 16, width of ldr_addra.
- DATA_WIDTH, 32, width of stream and write data.
- MAX_ADDR, 16'h7FFC, highest loadable byte address. A write at this address triggers the bank swap downstream.
- SR_ADDR_REG, 4'h0, settings register index for the load address.
- SR_DATA_REG, 4'h1, settings register index for load data.
- ACK_TIMEOUT, 16, maximum cycles to wait for ldr_acka per write.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- i_tdata  in  DATA_WIDTH  firmware stream data.
- i_tlast  in  1  last word of the packet.
- i_tvalid  in  1  stream valid.
- i_tready  out  1  stream ready.
- ldr_stb  out  1  write strobe to the loader.
- ldr_wea  out  1  write enable; equals ldr_stb.
- ldr_addra  out  ADDR_WIDTH  {SR index, 2'b00}, zero-extended.
- ldr_dina  out  DATA_WIDTH  write data.
- ldr_acka  in  1  write ack.
- busy  out  1  packet in progress.
- done  out  1  one-cycle pulse: packet completed cleanly.
- swapped  out  1  one-cycle pulse: word at MAX_ADDR acked (bank swap).
- err  out  1  one-cycle pulse: packet aborted.
- err_code  out  2  1 = bad header, 2 = overflow, 3 = ack timeout; holds until the next packet starts.
- word_count  out  14  data words acked in the current/last packet.
- checksum  out  32  mod-2^32 sum of acked data words.

Behaviour:
- Reset values: all outputs 0; state IDLE; internal address 0.
- States: IDLE, ADDR_WR, DATA_WAIT, DATA_WR, GAP, DRAIN.
- IDLE:
  - i_tready=1. On the header beat: clear word_count, checksum and err_code; set busy.
  - Bad header (addr[1:0]!=0, addr>MAX_ADDR, or i_tlast=1): err=1 with code 1; go to DRAIN, or to IDLE if i_tlast was set.
  - Otherwise latch cur_addr=addr[14:2] and go to ADDR_WR.
- ADDR_WR:
  - ldr_stb=ldr_wea=1, ldr_addra={SR_ADDR_REG,2'b00}, ldr_dina=header.
  - Hold until ldr_acka, then deassert ldr_stb for exactly one cycle (GAP), then DATA_WAIT.
- DATA_WAIT:
  - i_tready=1. On a beat, latch data and last flag.
  - If {cur_addr,2'b00}>MAX_ADDR: err code 2; go to DRAIN, or to IDLE if the beat was last.
  - Otherwise go to DATA_WR.
- DATA_WR:
  - Strobe {SR_DATA_REG,2'b00} with the latched data; hold until ack.
  - On ack: word_count+1, checksum+=data, cur_addr+1 (13-bit wrap is never reached because of the overflow check).
  - If the acked address == MAX_ADDR, pulse swapped.
  - Then GAP, followed by DATA_WAIT, or by IDLE with done=1 if the word was last.
- Ack timing: ldr_stb never stays high in the cycle after ack. The minimum write period is 3 cycles (stb, ack, gap).
- Timeout: a counter restarts at each new strobe. If ACK_TIMEOUT cycles elapse without ack, drop ldr_stb, pulse err with code 3, and go to DRAIN (IDLE if the pending word was last).
- DRAIN: i_tready=1; discard beats until i_tlast, then IDLE.
- busy is high everywhere except IDLE.
- i_tready is 0 in ADDR_WR, DATA_WR and GAP.
- ldr_addra and ldr_dina are stable for the whole duration of ldr_stb.
- Simultaneous events:
  - Ack in the same cycle as the timeout expiry counts as ack.
  - Last word at MAX_ADDR gives swapped and done in the same cycle.
- rst_n low mid-write: ldr_stb drops immediately (asynchronously). The partial packet is abandoned; upstream must resend the full packet.

Test Plan:
- Header 0x7FF4 followed by 3 words A,B,C (last=C) with ack 1 cycle after stb:
  - 4 writes: addr-reg 0x7FF4, then data at 0x7FF4, 0x7FF8, 0x7FFC.
  - swapped and done pulse together; word_count=3; checksum=A+B+C.
- Header 0x0002 with 2 data words:
  - err code 1, no ldr_stb, both data beats drained.
  - Next valid packet loads normally.
- Header 0x7FFC with data words X, Y (last=Y):
  - X written, swapped=1; Y triggers err code 2.
  - word_count=1, done never asserted.
- ldr_acka held low on the first data write:
  - ldr_stb drops after 16 cycles; err code 3.
  - Remaining beats drained; i_tready=1 until tlast.
- Random i_tvalid gaps and 0–5 cycle ack latency over a 64-word image:
  - Write order and data match the stream.
  - No stb in the cycle after ack.
- rst_n asserted during DATA_WR:
  - All outputs 0 immediately; next full packet loads correctly.
